// File: rtl/voting_machine_param.sv
// Parametrised voting machine: counts button releases per candidate during a session
// and publishes counts, winner index and tie flag when voting ends.
module voting_machine_param #(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 15,
  parameter int IDX_W       = $clog2(NUM_CAND)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [NUM_CAND-1:0]       i_candidate,
  input  logic                      i_voting_over,
  output logic [NUM_CAND*CNT_W-1:0] o_count,
  output logic [IDX_W-1:0]          o_winner,
  output logic                      o_tie,
  output logic                      o_results_valid,
  output logic                      o_vote_accepted,
  output logic                      o_vote_rejected,
  output logic [1:0]                o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VOTE   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e                    state_q, state_d;
  logic [NUM_CAND-1:0]       prev_q, prev_d;
  logic [CNT_W-1:0]          cnt_q [NUM_CAND];
  logic [CNT_W-1:0]          cnt_d [NUM_CAND];
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [NUM_CAND*CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0]          winner_q, winner_d;
  logic                      tie_q, tie_d;
  logic                      valid_q, valid_d;
  logic                      acc_q, acc_d;
  logic                      rej_q, rej_d;

  logic [NUM_CAND-1:0] rel;
  logic [IDX_W-1:0]    rel_idx;
  logic                rel_any, rel_multi;
  logic [CNT_W-1:0]    max_v;
  logic [IDX_W-1:0]    win_v;
  logic                tie_v;

  // Release decode: index of the (single) released button, plus multi-release flag.
  always_comb begin
    rel       = prev_q & ~i_candidate;
    rel_any   = |rel;
    rel_multi = (rel & (rel - NUM_CAND'(1))) != '0;
    rel_idx   = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      if (rel[k]) rel_idx = IDX_W'(k);
    end
  end

  // Strict '>' keeps the lowest index on ties; all-zero counts naturally give tie=1.
  always_comb begin
    max_v = cnt_q[0];
    win_v = '0;
    tie_v = 1'b0;
    for (int k = 1; k < NUM_CAND; k++) begin
      if (cnt_q[k] > max_v) begin
        max_v = cnt_q[k];
        win_v = IDX_W'(k);
        tie_v = 1'b0;
      end else if (cnt_q[k] == max_v) begin
        tie_v = 1'b1;
      end
    end
  end

  // NOTE: every _d gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    prev_d   = i_candidate;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    count_d  = count_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    acc_d    = 1'b0;
    rej_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_VOTE;
          for (int k = 0; k < NUM_CAND; k++) cnt_d[k] = '0;
        end
      end
      ST_VOTE: begin
        if (i_voting_over) begin
          state_d = ST_FINISH;
        end else if (rel_multi) begin
          rej_d = 1'b1;
        end else if (rel_any) begin
          if (cnt_q[rel_idx] != '1) begin
            cnt_d[rel_idx] = cnt_q[rel_idx] + CNT_W'(1);
            acc_d          = 1'b1;
            state_d        = ST_HOLD;
            hold_d         = '0;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (i_voting_over) begin
          state_d = ST_FINISH;
        end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_VOTE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_FINISH: begin
        if (!i_voting_over) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Publish on the edge that enters FINISH.
    if (state_d == ST_FINISH && state_q != ST_FINISH) begin
      for (int k = 0; k < NUM_CAND; k++) count_d[k*CNT_W +: CNT_W] = cnt_q[k];
      winner_d = win_v;
      tie_d    = tie_v;
    end

    valid_d = (state_d == ST_FINISH);
  end

  // NOTE: non-blocking assignments only here, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      hold_q   <= '0;
      count_q  <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so clearing it on reset is cheap.
      for (int k = 0; k < NUM_CAND; k++) cnt_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      hold_q   <= hold_d;
      count_q  <= count_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      rej_q    <= rej_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_count         = count_q;
  assign o_winner        = winner_q;
  assign o_tie           = tie_q;
  assign o_results_valid = valid_q;
  assign o_vote_accepted = acc_q;
  assign o_vote_rejected = rej_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_voting_machine_param.sv
// Directed bench for voting_machine_param (4 candidates, 2-bit counters, 15-cycle hold).
module tb_voting_machine_param;

  localparam int NUM_CAND = 4;
  localparam int CNT_W    = 2;
  localparam int HOLD     = 15;
  localparam int IDX_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      i_start;
  logic [NUM_CAND-1:0]       i_candidate;
  logic                      i_voting_over;
  logic [NUM_CAND*CNT_W-1:0] o_count;
  logic [IDX_W-1:0]          o_winner;
  logic                      o_tie;
  logic                      o_results_valid;
  logic                      o_vote_accepted;
  logic                      o_vote_rejected;
  logic [1:0]                o_state;

  int n_checks = 0;
  int n_errors = 0;

  voting_machine_param #(
    .NUM_CAND(NUM_CAND), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_candidate(i_candidate),
    .i_voting_over(i_voting_over), .o_count(o_count), .o_winner(o_winner),
    .o_tie(o_tie), .o_results_valid(o_results_valid),
    .o_vote_accepted(o_vote_accepted), .o_vote_rejected(o_vote_rejected),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs read then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input int k);
    i_candidate = NUM_CAND'(1 << k);
    tick();
    i_candidate = '0;
    tick();
  endtask

  task automatic wait_vote();
    for (int i = 0; i < 40 && o_state != 2'd1; i++) tick();
    check("wait_vote", o_state, 2'd1);
  endtask

  task automatic accept(input string tag, input int k);
    vote(k);
    check(tag, {o_vote_accepted, o_vote_rejected}, 2'b10);
    wait_vote();
  endtask

  task automatic start_session();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    int  n_hold;
    logic any_pulse;
    rst = 1'b1; i_start = 1'b0; i_candidate = '0; i_voting_over = 1'b0;
    tick(); tick();
    check("rst_state", o_state, 2'd0);
    check("rst_outs", {o_count, o_winner, o_tie, o_results_valid, o_vote_accepted, o_vote_rejected}, '0);
    rst = 1'b0;

    // Single vote for candidate 2 and exact hold length, with a release dropped in HOLD.
    start_session();
    check("start_vote", o_state, 2'd1);
    vote(2);
    check("acc_c2", {o_vote_accepted, o_vote_rejected, o_state}, {2'b10, 2'd2});
    n_hold = 1;
    any_pulse = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) i_candidate = 4'b0010;
      if (i == 4) i_candidate = 4'b0000;
      tick();
      any_pulse |= o_vote_accepted | o_vote_rejected;
      if (o_state == 2'd2) n_hold++;
      else break;
    end
    check("hold_len", n_hold, HOLD);
    check("hold_exit", o_state, 2'd1);
    check("hold_rel_drop", any_pulse, 1'b0);

    // Two simultaneous releases.
    i_candidate = 4'b1010; tick();
    i_candidate = 4'b0000; tick();
    check("multi_rej", {o_vote_accepted, o_vote_rejected, o_state}, {2'b01, 2'd1});
    tick();
    check("rej_pulse_1cyc", o_vote_rejected, 1'b0);

    i_voting_over = 1'b1; tick();
    check("fin1_state", {o_state, o_results_valid}, {2'd3, 1'b1});
    check("fin1_count", o_count, 8'h10);
    check("fin1_win", {o_winner, o_tie}, {2'd2, 1'b0});
    i_voting_over = 1'b0; tick();
    check("idle_after", {o_state, o_results_valid}, {2'd0, 1'b0});
    check("count_held", o_count, 8'h10);

    // Saturation of candidate 0, then votes 3,3,1,0 (tie between 0 and 1).
    start_session();
    accept("sat_v1", 0);
    accept("sat_v2", 0);
    accept("sat_v3", 0);
    vote(0);
    check("sat_rej", {o_vote_accepted, o_vote_rejected, o_state}, {2'b01, 2'd1});
    accept("c1_v1", 1);
    accept("c1_v2", 1);
    accept("c1_v3", 1);
    accept("c2_v1", 2);
    i_voting_over = 1'b1; tick();
    check("fin2_count", o_count, 8'h1F);
    check("fin2_win", {o_winner, o_tie}, {2'd0, 1'b1});
    i_voting_over = 1'b0; tick();

    // Empty session.
    start_session();
    i_voting_over = 1'b1; tick();
    check("fin3_count", o_count, 8'h00);
    check("fin3_win", {o_winner, o_tie, o_results_valid}, {2'd0, 1'b1, 1'b1});
    i_voting_over = 1'b0; tick();

    // voting_over wins against a same-cycle release.
    start_session();
    i_candidate = 4'b0010; tick();
    i_candidate = 4'b0000; i_voting_over = 1'b1; tick();
    check("over_rel_pulse", {o_state, o_vote_accepted, o_vote_rejected}, {2'd3, 2'b00});
    check("over_rel_count", o_count, 8'h00);
    i_voting_over = 1'b0; tick();
    check("over_idle", {o_state, o_results_valid}, {2'd0, 1'b0});

    // Reset in the middle of HOLD with a button held across it.
    start_session();
    vote(3);
    check("acc_c3", {o_vote_accepted, o_state}, {1'b1, 2'd2});
    tick();
    i_candidate = 4'b0001; rst = 1'b1; tick();
    check("midhold_rst", {o_state, o_count, o_winner, o_tie, o_results_valid, o_vote_accepted, o_vote_rejected}, '0);
    rst = 1'b0; tick();
    i_candidate = 4'b0000; tick();
    check("held_rel", {o_state, o_vote_accepted, o_vote_rejected}, {2'd0, 2'b00});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/voting_machine_param.md
Name: voting_machine_param

Overview:
- Parametrised successor to the three-candidate voting machine. Supports NUM_CAND candidates with configurable counter width and lockout length.
- Adds explicit session start, rejection of simultaneous or saturating votes, accept/reject pulses, and on-chip winner/tie resolution.
- Sits between debounced candidate pushbuttons and the results display/readout logic.

Parameters:
- NUM_CAND, 4, number of candidates (2..16).
- CNT_W, 16, width of each vote counter (1..32).
- HOLD_CYCLES, 15, lockout cycles after an accepted vote (>=1).
- IDX_W, $clog2(NUM_CAND), width of the winner index (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_start  in  1  begins a new session while in IDLE.
- i_candidate  in  NUM_CAND  candidate buttons, bit k = candidate k; a vote is the 1->0 release.
- i_voting_over  in  1  level; ends the session and publishes results.
- o_count  out  NUM_CAND*CNT_W  published counts; candidate k occupies bits [k*CNT_W +: CNT_W].
- o_winner  out  IDX_W  index of the highest count; lowest index wins ties.
- o_tie  out  1  1 when two or more candidates share the maximum count.
- o_results_valid  out  1  1 while in FINISH.
- o_vote_accepted  out  1  one-cycle pulse per counted vote.
- o_vote_rejected  out  1  one-cycle pulse per discarded vote attempt in VOTE.
- o_state  out  2  current state: IDLE=0, VOTE=1, HOLD=2, FINISH=3.

Behaviour:
- Reset: all registers clear; state IDLE; o_count, o_winner, o_tie, o_results_valid and both pulses = 0; prev-button register = 0. Reset has priority in every state, including mid-HOLD and FINISH.
- Release detect: rel = prev & ~i_candidate. prev <= i_candidate on every cycle in every state, so releases during IDLE/HOLD/FINISH are dropped, never queued.
- IDLE: on i_start=1, go to VOTE next cycle, clear internal counters, drop o_results_valid. o_count/o_winner/o_tie keep the last published values until the next FINISH.
- VOTE, in priority order:
  - i_voting_over=1 -> FINISH; any same-cycle release is discarded with no pulse.
  - rel one-hot at bit k and counter k < 2^CNT_W-1: counter k +1; o_vote_accepted=1 next cycle; state HOLD next cycle.
  - rel one-hot at bit k and counter k saturated: no increment; o_vote_rejected=1 next cycle; stay in VOTE.
  - rel has >=2 bits set: no count; o_vote_rejected=1 next cycle; stay in VOTE.
  - rel = 0: stay in VOTE.
- HOLD: runs exactly HOLD_CYCLES cycles (hold counter 0..HOLD_CYCLES-1, cleared on entry), then VOTE. i_voting_over=1 -> FINISH immediately.
- FINISH entry (same edge as the transition):
  - o_count <= internal counters.
  - o_winner <= lowest index holding the maximum count.
  - o_tie <= (more than one index holds the maximum).
  - All counts zero -> winner=0, tie=1.
  - o_results_valid=1 throughout FINISH.
- FINISH exit: i_voting_over=0 -> IDLE next cycle; o_results_valid drops on entry to IDLE.
- i_start is ignored outside IDLE. i_voting_over is ignored in IDLE.
- Latency: release seen at cycle t -> pulse and updated count at t+1. i_voting_over seen at t -> results valid at t+1.
- Arithmetic: counters are unsigned CNT_W bits and never wrap.

Test Plan:
- Reset then start, N=4: release cand 2 once -> accepted pulse at t+1, state HOLD for exactly 15 cycles, then VOTE. After voting_over: o_count = {0,1,0,0}, winner=2, tie=0.
- Release cand 1 during HOLD -> no count, no pulse. Release cand 1 and cand 3 in the same cycle in VOTE -> rejected pulse, counts unchanged.
- CNT_W=2: four releases of cand 0 -> counts 1,2,3, then rejected pulse. o_count[0]=3 after finish.
- Votes 3,3,1,0 -> winner=0, tie=1. No votes at all -> winner=0, tie=1.
- voting_over asserted in the same cycle as a cand 1 release -> FINISH with the vote discarded, no pulse. Deassert -> IDLE, results_valid=0, o_count held. Start -> internal counts cleared.
- rst asserted mid-HOLD with counts nonzero -> next cycle state IDLE, all outputs 0. A button held across reset and released afterward causes no vote.
